// File: rtl/gate_check_pkg.sv
// Shared types and constants for the 2-input gate response checker.
// Holds the FSM state encoding, vector count/width and a small helper.
package gate_check_pkg;

    localparam int NUM_VECTORS = 4;
    localparam int VEC_W       = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef logic [VEC_W-1:0] vec_t;

    // True when v is the final vector of an exhaustive run.
    function automatic logic is_last(input vec_t v);
        return v == vec_t'(NUM_VECTORS - 1);
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Down-counter that times the settle interval between stimulus and sample.
// Ports: clk, rst (sync, active-high), load (restart interval), expire (pulse).
module settle_timer #(
    parameter int CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 4'd0;
        end else if (load) begin
            count <= 4'(CYCLES);
        end else if (count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    // Loading at edge E makes expire visible for the edge E+CYCLES.
    assign expire = (count == 4'd1);

endmodule

// File: rtl/gate_response_checker.sv
// Exhaustively drives the four input vectors of a 2-input gate and compares
// each response against a latched golden truth table.
// Ports: clk, rst, start, expected[3:0], y_in -> a_out, b_out, busy, done,
//        pass, fail_mask[3:0], error_count[2:0].
module gate_response_checker
    import gate_check_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] expected,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [2:0] error_count
);

    state_t     state, state_n;
    vec_t       idx, idx_n;
    logic [3:0] exp_q, exp_n;
    logic [3:0] mask_q, mask_n;
    logic [2:0] err_q, err_n;
    logic       pass_q, pass_n;
    logic       busy_q, busy_n;
    logic       done_q, done_n;
    logic       load;
    logic       expire;

    settle_timer #(
        .CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            exp_q  <= '0;
            mask_q <= '0;
            err_q  <= '0;
            pass_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            exp_q  <= exp_n;
            mask_q <= mask_n;
            err_q  <= err_n;
            pass_q <= pass_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        exp_n   = exp_q;
        mask_n  = mask_q;
        err_n   = err_q;
        pass_n  = pass_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SETTLE;
                    exp_n   = expected;
                    mask_n  = '0;
                    err_n   = '0;
                    pass_n  = 1'b0;
                    idx_n   = '0;
                    busy_n  = 1'b1;
                    load    = 1'b1;
                end
            end
            SETTLE: begin
                if (expire) begin
                    if (y_in != exp_q[idx]) begin
                        mask_n[idx] = 1'b1;
                        err_n       = err_q + 3'd1;
                    end
                    if (is_last(idx)) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (err_n == 3'd0);
                        idx_n   = '0;
                    end else begin
                        // Next vector goes out on the same edge as this sample.
                        idx_n = idx + vec_t'(1);
                        load  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Vector index doubles as {a,b}; it is zero outside SETTLE.
    assign a_out       = idx[1];
    assign b_out       = idx[0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_mask   = mask_q;
    assign error_count = err_q;

endmodule

// File: doc/gate_response_checker.md
GATE_RESPONSE_CHECKER -- requirements
Module: gate_response_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning clock cycles between driving a stimulus vector and sampling the DUT response (legal range 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port start  input  1  begins one exhaustive run when sampled high in IDLE.
REQ-005 SHALL have port expected  input  4  golden truth table; bit index = {a,b}, e.g. AND = 4'b1000.
REQ-006 SHALL have port y_in  input  1  response from the 2-input gate under test.
REQ-007 SHALL have ports a_out and b_out  output  1 each  stimulus to the gate under test.
REQ-008 SHALL have port busy  output  1  high while a run is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse at end of run.
REQ-010 SHALL have port pass  output  1  high when the last completed run had zero mismatches.
REQ-011 SHALL have port fail_mask  output  4  bit k set when vector k mismatched in the last run.
REQ-012 SHALL have port error_count  output  3  number of mismatches in the last run (0..4).

Function
REQ-013 SHALL implement FSM states IDLE, SETTLE, DONE; IDLE->SETTLE on start, SETTLE->SETTLE between vectors, SETTLE->DONE after vector 3 sampled, DONE->IDLE unconditionally next cycle.
REQ-014 SHALL, at edge E0 where start=1 in IDLE: latch expected, clear fail_mask/error_count/pass, set vector index 0, drive {a_out,b_out}=2'b00, assert busy.
REQ-015 SHALL sample y_in for vector k at edge E0+(k+1)*SETTLE_CYCLES and compare against latched expected[k].
REQ-016 SHALL, on mismatch at vector k, set fail_mask[k] and increment error_count at that same edge.
REQ-017 SHALL, at the sampling edge of vector k<3, drive vector k+1 on {a_out,b_out} in the same edge.
REQ-018 SHALL, at edge E0+4*SETTLE_CYCLES, enter DONE: busy=0, done=1 for exactly one cycle, pass=(error_count==0 including vector 3 result).
REQ-019 SHALL hold pass, fail_mask, error_count stable from DONE until the next accepted start.
REQ-020 SHALL drive {a_out,b_out}=2'b00 in IDLE and DONE.
REQ-021 SHALL ignore start while busy or in DONE; start held high continuously re-triggers only on return to IDLE.
REQ-022 SHALL ignore changes on expected after E0 for the remainder of the run.
REQ-023 SHALL never wrap error_count (max 4 fits 3 bits).

Reset
REQ-024 SHALL, on rst=1 at any edge including mid-run, enter IDLE with a_out=0, b_out=0, busy=0, done=0, pass=0, fail_mask=0, error_count=0, settle counter=0, index=0.
REQ-025 SHALL give rst priority over start in the same cycle.

Structure
REQ-026 SHALL place the FSM state enum, vector-count constant (4) and vector width (2) in shared package gate_check_pkg.
REQ-027 SHALL use one sub-module settle_timer (load, count-down, expire pulse) for the SETTLE_CYCLES interval.

Verification
REQ-028 Loopback y_in=a_out&b_out, expected=4'b1000, SETTLE_CYCLES=2, start at E0 -> stimulus 00,01,10,11 at E0,E0+2,E0+4,E0+6; done at E0+8; pass=1, fail_mask=0000, error_count=0.
REQ-029 y_in tied 0, expected=4'b1000 -> pass=0, fail_mask=1000, error_count=1.
REQ-030 y_in=~(a_out&b_out), expected=4'b1000 -> pass=0, fail_mask=1111, error_count=4.
REQ-031 Loopback AND, start re-pulsed at E0+3 and expected changed to 4'b0110 at E0+3 -> ignored; single done at E0+8, pass=1.
REQ-032 rst=1 at E0+5 -> next cycle all outputs zero, state IDLE; new start yields full correct run.
REQ-033 SETTLE_CYCLES=1, loopback OR with expected=4'b1110 -> done at E0+4, pass=1.
